// File: rtl/calc_op_sequencer.sv
// Multi-cycle signed calculator: add/sub in one EXEC cycle, multiply by 16-step shift-add.
// Optional signed-overflow flag enabled by defining CALC_OVF_EN.
module calc_op_sequencer (
   input  logic        clk,
   input  logic        RST,
   input  logic        start,
   input  logic [2:0]  opcode,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        ovf,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, EXEC, MUL, SIGN, DONE} state_t;

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b100;

`ifdef CALC_OVF_EN
   localparam int PW = 32;
`else
   localparam int PW = 16;
`endif

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic [2:0]  opc_q, opc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [16:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] result_q, result_d;
   logic        err_q, err_d;
`ifdef CALC_OVF_EN
   logic        ovf_q, ovf_d;
`endif

   logic [15:0]   sum, diff;
   logic [16:0]   ext_a, ext_b, mag_a, mag_b;
   logic [PW-1:0] prod;

   assign sum   = a_q + b_q;
   assign diff  = a_q - b_q;
   // 17-bit magnitudes so that -32768 becomes +32768 without wrapping
   assign ext_a = {a_q[15], a_q};
   assign ext_b = {b_q[15], b_q};
   assign mag_a = a_q[15] ? (~ext_a + 17'd1) : ext_a;
   assign mag_b = b_q[15] ? (~ext_b + 17'd1) : ext_b;
   // Only the low result bits are needed unless the overflow check is built
   assign prod  = neg_q ? (~acc_q[PW-1:0] + PW'(1)) : acc_q[PW-1:0];

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      opc_d    = opc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      err_d    = err_q;
`ifdef CALC_OVF_EN
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = op_a;
               b_d     = op_b;
               opc_d   = opcode;
               err_d   = 1'b0;
`ifdef CALC_OVF_EN
               ovf_d   = 1'b0;
`endif
               busy_d  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            unique case (opc_q)
               OP_ADD: begin
                  result_d = sum;
`ifdef CALC_OVF_EN
                  ovf_d    = (a_q[15] == b_q[15]) && (sum[15] != a_q[15]);
`endif
                  done_d   = 1'b1;
                  state_d  = DONE;
               end
               OP_SUB: begin
                  result_d = diff;
`ifdef CALC_OVF_EN
                  ovf_d    = (a_q[15] != b_q[15]) && (diff[15] != a_q[15]);
`endif
                  done_d   = 1'b1;
                  state_d  = DONE;
               end
               OP_MUL: begin
                  mcand_d  = {15'd0, mag_a};
                  mplier_d = mag_b;
                  acc_d    = 32'd0;
                  cnt_d    = 5'd0;
                  neg_d    = a_q[15] ^ b_q[15];
                  state_d  = MUL;
               end
               default: begin
                  result_d = 16'd0;
                  err_d    = 1'b1;
`ifdef CALC_OVF_EN
                  ovf_d    = 1'b0;
`endif
                  done_d   = 1'b1;
                  state_d  = DONE;
               end
            endcase
         end
         MUL: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd15) state_d = SIGN;
         end
         SIGN: begin
            result_d = prod[15:0];
`ifdef CALC_OVF_EN
            // In range iff bits 31..15 are all copies of the sign
            ovf_d    = !((&prod[31:15]) || !(|prod[31:15]));
`endif
            done_d   = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q  <= IDLE;
         a_q      <= 16'd0;
         b_q      <= 16'd0;
         opc_q    <= 3'd0;
         mcand_q  <= 32'd0;
         mplier_q <= 17'd0;
         acc_q    <= 32'd0;
         cnt_q    <= 5'd0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 16'd0;
         err_q    <= 1'b0;
`ifdef CALC_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opc_q    <= opc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef CALC_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign err    = err_q;
`ifdef CALC_OVF_EN
   assign ovf    = ovf_q;
`else
   assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed + random bench for calc_op_sequencer against an arithmetic reference model.
// Latency k counts rising edges after the edge that accepted start.
module tb_calc_op_sequencer;

   logic        clk = 1'b0;
   logic        RST;
   logic        start;
   logic [2:0]  opcode;
   logic [15:0] op_a, op_b;
   logic        busy, done, ovf, err;
   logic [15:0] result;

   int tests = 0;
   int fails = 0;

   calc_op_sequencer dut (
      .clk(clk), .RST(RST), .start(start), .opcode(opcode),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
      .result(result), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer arithmetic, then truncate / range-check.
   task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic o, output logic e, output int lat);
      int ai, bi, s;
      logic [31:0] sv;
      ai = int'($signed(a));
      bi = int'($signed(b));
      e = 1'b0; s = 0; lat = 1;
      case (op)
         3'b001: s = ai + bi;
         3'b010: s = ai - bi;
         3'b100: begin s = ai * bi; lat = 18; end
         default: e = 1'b1;
      endcase
      sv = s;
      r = sv[15:0];
`ifdef CALC_OVF_EN
      o = !e && (s > 32767 || s < -32768);
`else
      o = 1'b0;
`endif
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int ign_at);
      logic [15:0] er;
      logic eo, ee;
      int lat, k;
      model(op, a, b, er, eo, ee, lat);
      start = 1'b1; opcode = op; op_a = a; op_b = b;
      @(posedge clk); #1;
      start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); opcode = 3'($urandom);
      check({tag, ".busy0"}, busy, 1'b1);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == ign_at) begin
            start = 1'b1; opcode = 3'b001; op_a = 16'($urandom); op_b = 16'($urandom);
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin k = i; break; end
         check({tag, ".busy"}, busy, 1'b1);
      end
      check({tag, ".lat"}, k, lat);
      check({tag, ".res"}, result, er);
      check({tag, ".ovf"}, ovf, eo);
      check({tag, ".err"}, err, ee);
      check({tag, ".busyD"}, busy, 1'b1);
      @(posedge clk); #1;
      check({tag, ".pulse"}, {busy, done}, 2'b00);
      check({tag, ".hold"}, {result, ovf, err}, {er, eo, ee});
   endtask

   initial begin
      logic [2:0] ops [4];
      int ndone;
      ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b100; ops[3] = 3'b011;
      RST = 1'b1; start = 1'b0; opcode = 3'd0; op_a = 16'd0; op_b = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", {busy, done, result, ovf, err}, 20'd0);
      RST = 1'b0;
      @(posedge clk); #1;

      run_op("add2p3", 3'b001, 16'd2, 16'd3, 0);
      run_op("sub3m5", 3'b010, 16'd3, 16'd5, 0);
      run_op("subMinM1", 3'b010, 16'h8000, 16'd1, 0);
      run_op("mulN3N6", 3'b100, 16'hFFFD, 16'hFFFA, 0);
      run_op("mul128x256", 3'b100, 16'd128, 16'd256, 0);
      run_op("mulMinx1", 3'b100, 16'h8000, 16'd1, 0);
      run_op("mulMinxMin", 3'b100, 16'h8000, 16'h8000, 0);
      run_op("mulIgn", 3'b100, 16'd300, 16'hFF9C, 5);
      run_op("illegal011", 3'b011, 16'd7, 16'd9, 0);
      run_op("illegal000", 3'b000, 16'd7, 16'd9, 0);
      run_op("add7", 3'b001, 16'd7, 16'd0, 0);

      // Reset in the middle of a multiply
      start = 1'b1; opcode = 3'b100; op_a = 16'd1000; op_b = 16'd1000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1; RST = 1'b1;
      @(posedge clk); #1;
      RST = 1'b0;
      check("rstMid", {busy, done, result, ovf, err}, 20'd0);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      check("rstMidQuiet", ndone, 0);
      run_op("addAfterRst", 3'b001, 16'd2, 16'd3, 0);

      // start together with reset is dropped
      RST = 1'b1; start = 1'b1; opcode = 3'b001;
      @(posedge clk); #1;
      RST = 1'b0; start = 1'b0;
      check("rstStart", {busy, done}, 2'b00);
      @(posedge clk); #1;
      check("rstStart2", {busy, done}, 2'b00);

      for (int n = 0; n < 24; n++)
         run_op("rand", ops[$urandom_range(0, 3)], 16'($urandom), 16'($urandom), 0);
      for (int n = 0; n < 6; n++)
         run_op("randSmallMul", 3'b100, 16'($signed(8'($urandom))), 16'($signed(8'($urandom))), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
